// File: rtl/masked_share_gen.sv
// Operand front end for the masked adder: splits a and b into two Boolean shares
// using fresh masks from a 16-bit Galois LFSR, behind a registered valid/ready output.
module masked_share_gen #(
    parameter int unsigned WIDTH  = 4,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int unsigned WARMUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] b0,
    output logic [WIDTH-1:0] b1,
    output logic [7:0]       txn_count
);

    typedef enum logic [1:0] {ST_WARMUP, ST_EMPTY, ST_FULL} state_t;

    // A zero seed would lock the LFSR at zero, so it is never allowed in.
    localparam logic [15:0] SEED_NZ   = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [15:0] WARM_LAST = (WARMUP == 0) ? 16'd0 : 16'(WARMUP - 1);
    localparam state_t      ST_INIT   = (WARMUP == 0) ? ST_EMPTY : ST_WARMUP;

    state_t             r_state;
    state_t             w_state_next;
    logic [15:0]        r_lfsr;
    logic [15:0]        w_lfsr_next;
    logic [15:0]        r_warm_cnt;
    logic [15:0]        w_warm_next;
    logic               w_lfsr_step;
    logic               w_accept;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_a0;
    logic [WIDTH-1:0]   r_a1;
    logic [WIDTH-1:0]   r_b0;
    logic [WIDTH-1:0]   r_b1;
    logic [7:0]         r_txn_count;
    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;

    assign in_ready  = ((r_state == ST_EMPTY) | ((r_state == ST_FULL) & out_ready)) & ~seed_load;
    assign w_accept  = in_valid & in_ready;
    assign w_ma      = r_lfsr[WIDTH-1:0];
    assign w_mb      = r_lfsr[2*WIDTH-1:WIDTH];
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        w_state_next = r_state;
        w_warm_next  = r_warm_cnt;
        w_lfsr_step  = 1'b0;
        if (seed_load) begin
            w_state_next = ST_INIT;
            w_warm_next  = '0;
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    w_lfsr_step = 1'b1;
                    if (r_warm_cnt == WARM_LAST) begin
                        w_state_next = ST_EMPTY;
                        w_warm_next  = '0;
                    end else begin
                        w_warm_next = r_warm_cnt + 16'd1;
                    end
                end
                ST_EMPTY: begin
                    if (in_valid) begin
                        w_state_next = ST_FULL;
                        w_lfsr_step  = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        w_state_next = in_valid ? ST_FULL : ST_EMPTY;
                        w_lfsr_step  = in_valid;
                    end
                end
                default: w_state_next = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_lfsr      <= SEED_NZ;
            r_warm_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_a0        <= '0;
            r_a1        <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_txn_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_warm_cnt  <= w_warm_next;
            r_out_valid <= (w_state_next == ST_FULL);
            if (seed_load) begin
                r_lfsr <= (seed == 16'h0) ? SEED_NZ : seed;
            end else if (w_lfsr_step) begin
                r_lfsr <= w_lfsr_next;
            end
            // Masks come from the pre-step LFSR value on the accepting edge.
            if (w_accept) begin
                r_a0        <= a ^ w_ma;
                r_a1        <= w_ma;
                r_b0        <= b ^ w_mb;
                r_b1        <= w_mb;
                r_txn_count <= r_txn_count + 8'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign a0        = r_a0;
    assign a1        = r_a1;
    assign b0        = r_b0;
    assign b1        = r_b1;
    assign txn_count = r_txn_count;

endmodule

// File: doc/masked_share_gen.md
Name: masked_share_gen

Overview:
- Front end of the masked adder datapath. Accepts plain operands a and b over a valid/ready handshake.
- Splits each operand into two Boolean shares using fresh masks from an internal 16-bit LFSR.
- Presents the shares a0/a1/b0/b1 on a registered valid/ready output that feeds the pipelined masked RCA share inputs.
- Invariants: a0^a1 == a and b0^b1 == b.

Parameters:
- WIDTH, 4, operand and share width; 2*WIDTH must be <= 16.
- SEED, 16'hACE1, LFSR reset value; also substituted for any zero seed.
- WARMUP, 4, LFSR steps after reset or seed load before the first accept; 0 is legal.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  plain operand a.
- b  in  WIDTH  plain operand b.
- seed_load  in  1  synchronous pulse: reload the LFSR.
- seed  in  16  value loaded on seed_load.
- out_valid  out  1  shares valid.
- out_ready  in  1  downstream accepts shares.
- a0  out  WIDTH  a ^ ma.
- a1  out  WIDTH  ma.
- b0  out  WIDTH  b ^ mb.
- b1  out  WIDTH  mb.
- txn_count  out  8  number of accepted transactions, wraps.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - lfsr=SEED, state=WARMUP (or EMPTY if WARMUP==0), warm_cnt=0.
  - out_valid=0, a0=a1=b0=b1=0, txn_count=0, in_ready=0.
- LFSR: 16-bit Galois, right shift.
  - next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 16'h0).
  - Steps only on a warmup cycle or an accepted input; otherwise holds.
  - Can never reach 0.
- Masks are taken from the LFSR value before it steps on the accepting cycle:
  - ma = lfsr[WIDTH-1:0]
  - mb = lfsr[2*WIDTH-1:WIDTH]
- FSM states: WARMUP, EMPTY, FULL.
  - WARMUP: in_ready=0. Each cycle the LFSR steps and warm_cnt increments. After WARMUP steps → EMPTY, with warm_cnt cleared.
  - EMPTY: in_ready=1. in_valid → register shares, out_valid=1, txn_count+1, LFSR steps, → FULL.
  - FULL: out_valid=1 and the shares are stable until out_ready.
    - out_ready with in_valid: back-to-back. New shares load the same cycle; stay FULL.
    - out_ready without in_valid: out_valid=0, → EMPTY.
- in_ready = ((state==EMPTY) | (state==FULL & out_ready)) & ~seed_load. It is combinational, so full throughput is 1 transaction per cycle.
- Latency: an operand accepted at edge N has its shares valid from edge N onward, i.e. out_valid rises in the following cycle.
- seed_load (any state, highest priority):
  - lfsr = (seed==0) ? SEED : seed.
  - Any pending output is discarded: out_valid=0; share registers keep their values but are invalid.
  - warm_cnt=0, → WARMUP (EMPTY if WARMUP==0).
  - A coincident in_valid is not accepted.
  - A coincident out_ready is not a handshake.
- txn_count wraps 255→0. It is not cleared by seed_load.
- Outputs change only on the clk edge or on reset; no combinational path from a/b to the shares.
- Reset asserted mid-transaction: the pending output is lost and all state returns to reset values immediately.

Test Plan:
- Reset, WARMUP=4 → in_ready=0 for 4 cycles, then 1. LFSR sequence ACE1, E270, 7138, 389C, 1C4E.
- First accept a=3, b=5 (lfsr=1C4E) → next cycle: out_valid=1, a0=D, a1=E, b0=1, b1=4, txn_count=1.
- Back-to-back: hold out_ready=1, second accept a=F, b=0 (lfsr=0E27) → a0=8, a1=7, b0=2, b1=2, no bubble, txn_count=2.
- Backpressure: out_ready=0 for 5 cycles while FULL → in_ready=0. Shares stable, LFSR frozen. Release → the transfer completes exactly once.
- seed_load with seed=0 while FULL → out_valid=0 next cycle, lfsr=ACE1, 4 warmup cycles. First masks again from 1C4E, giving a repeat of the first-accept scenario's values.
- Random soak, 1000 transactions, random stalls → always a0^a1==a and b0^b1==b. txn_count = accepts mod 256. Asynchronous reset mid-stream → out_valid=0 immediately.
